// File: rtl/hazard3_timer_pkg.sv
// Shared register map and APB address decode for the multi-hart timer-compare scheduler.
package hazard3_timer_pkg;

  localparam logic [15:0] ADDR_CTRL      = 16'h0000;
  localparam logic [15:0] ADDR_STATUS    = 16'h0004;
  localparam logic [15:0] ADDR_CMP_BASE  = 16'h0010;
  localparam logic [15:0] CMP_STRIDE     = 16'h0008;
  localparam logic [63:0] MTIMECMP_RESET = {64{1'b1}};

  typedef struct packed {
    logic       valid;
    logic       is_ctrl;
    logic       is_status;
    logic       is_cmp;
    logic       hi;
    logic [3:0] slot;
  } addr_dec_t;

  // Slot decode is bounded by the live hart count so addresses past the last slot error out.
  function automatic addr_dec_t decode_addr(input logic [15:0] addr, input int unsigned n_harts);
    addr_dec_t  d;
    logic [15:0] off;
    logic [15:0] slot_full;
    d         = '0;
    off       = addr - ADDR_CMP_BASE;
    slot_full = off / CMP_STRIDE;
    if (addr == ADDR_CTRL) begin
      d.valid   = 1'b1;
      d.is_ctrl = 1'b1;
    end else if (addr == ADDR_STATUS) begin
      d.valid     = 1'b1;
      d.is_status = 1'b1;
    end else if ((addr >= ADDR_CMP_BASE) && (addr[1:0] == 2'b00) &&
                 (32'(slot_full) < n_harts)) begin
      d.valid  = 1'b1;
      d.is_cmp = 1'b1;
      d.slot   = slot_full[3:0];
      d.hi     = off[2];
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard3_timer_cmp_sched_if.sv
// APB slave bus bundle for the timer-compare scheduler.
interface hazard3_timer_cmp_sched_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/hazard3_timer_scan_ctr.sv
// Wrapping round-robin slot index; holds while disabled.
module hazard3_timer_scan_ctr #(
  parameter int N_HARTS = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  output logic [((N_HARTS > 1) ? $clog2(N_HARTS) : 1)-1:0] idx
);
  localparam int IDX_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (en) begin
      if (idx == IDX_W'(N_HARTS - 1)) idx <= '0;
      else                            idx <= idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/hazard3_timer_cmp_sched.sv
// Per-hart mtimecmp bank sharing one 64-bit comparator, scanned round-robin against mtime.
module hazard3_timer_cmp_sched
  import hazard3_timer_pkg::*;
#(
  parameter int N_HARTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard3_timer_cmp_sched_if.slave apb,
  input  logic [63:0]          mtime,
  output logic [N_HARTS-1:0]   timer_irq
);
  localparam int IDX_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  addr_dec_t        dec;
  logic             access;
  logic             wr_en;
  logic             scan_en;
  logic [IDX_W-1:0] idx;
  logic [63:0]      cmp [N_HARTS];
  logic [63:0]      cur_cmp;
  logic [63:0]      rd_cmp;
  logic             hit;

  hazard3_timer_scan_ctr #(.N_HARTS(N_HARTS)) u_scan (
    .clk (clk),
    .rst (rst),
    .en  (scan_en),
    .idx (idx)
  );

  always_comb begin
    dec    = decode_addr(apb.paddr, N_HARTS);
    access = apb.psel && apb.penable;
    wr_en  = access && apb.pwrite && dec.valid;
  end

  // Shared comparator: only the slot under the scan index is compared this cycle.
  always_comb begin
    cur_cmp = MTIMECMP_RESET;
    rd_cmp  = '0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (idx == IDX_W'(i))      cur_cmp = cmp[i];
      if (dec.slot == 4'(i))     rd_cmp  = cmp[i];
    end
    hit = (mtime >= cur_cmp);
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access && !dec.valid;

  always_comb begin
    apb.prdata = '0;
    if (dec.is_ctrl)        apb.prdata = {31'd0, scan_en};
    else if (dec.is_status) apb.prdata = 32'(timer_irq);
    else if (dec.is_cmp)    apb.prdata = dec.hi ? rd_cmp[63:32] : rd_cmp[31:0];
  end

  // A compare-register write clears that hart's IRQ, taking priority over a same-cycle scan hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_en   <= 1'b1;
      timer_irq <= '0;
      for (int i = 0; i < N_HARTS; i++) cmp[i] <= MTIMECMP_RESET;
    end else begin
      if (wr_en && dec.is_ctrl) scan_en <= apb.pwdata[0];
      for (int i = 0; i < N_HARTS; i++) begin
        if (scan_en && (idx == IDX_W'(i))) timer_irq[i] <= hit;
        if (wr_en && dec.is_cmp && (dec.slot == 4'(i))) begin
          if (dec.hi) cmp[i][63:32] <= apb.pwdata;
          else        cmp[i][31:0]  <= apb.pwdata;
          timer_irq[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard3_timer_cmp_sched.sv
// Self-checking bench for hazard3_timer_cmp_sched with a cycle-level behavioural model.
module tb_hazard3_timer_cmp_sched;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   mtime;
  logic [N-1:0]  timer_irq;

  hazard3_timer_cmp_sched_if bus();

  hazard3_timer_cmp_sched #(.N_HARTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (bus),
    .mtime     (mtime),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: compare values, enable, IRQs and a count of enabled cycles.
  logic [63:0]  m_cmp [N];
  bit           m_en;
  logic [N-1:0] m_irq;
  int unsigned  m_phase;

  task automatic tick();
    logic [N-1:0] nirq;
    int s;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cmp[i] = {64{1'b1}};
      m_en    = 1'b1;
      m_irq   = '0;
      m_phase = 0;
    end else begin
      nirq = m_irq;
      s    = int'(m_phase % N);
      if (m_en) begin
        nirq[s] = (mtime >= m_cmp[s]);
        m_phase++;
      end
      if (bus.psel && bus.penable && bus.pwrite) begin
        if (bus.paddr == 16'h0000) m_en = bus.pwdata[0];
        for (int i = 0; i < N; i++) begin
          if (bus.paddr == 16'(16 + 8 * i)) begin
            m_cmp[i][31:0] = bus.pwdata;
            nirq[i] = 1'b0;
          end
          if (bus.paddr == 16'(20 + 8 * i)) begin
            m_cmp[i][63:32] = bus.pwdata;
            nirq[i] = 1'b0;
          end
        end
      end
      m_irq = nirq;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void model_read(input logic [15:0] a, output logic [31:0] d, output bit err);
    d   = '0;
    err = 1'b1;
    if (a == 16'h0000) begin d = {31'd0, m_en}; err = 1'b0; end
    if (a == 16'h0004) begin d = 32'(m_irq);    err = 1'b0; end
    for (int i = 0; i < N; i++) begin
      if (a == 16'(16 + 8 * i)) begin d = m_cmp[i][31:0];  err = 1'b0; end
      if (a == 16'(20 + 8 * i)) begin d = m_cmp[i][63:32]; err = 1'b0; end
    end
  endfunction

  task automatic apb_write(input logic [15:0] a, input logic [31:0] wd, output bit err);
    bus.paddr   = a;
    bus.pwdata  = wd;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    tick();
    bus.penable = 1'b1;
    #1;
    err = bus.pslverr;
    tick();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] rd, output bit err,
                          output logic [31:0] exp_rd, output bit exp_err);
    bus.paddr   = a;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    tick();
    bus.penable = 1'b1;
    #1;
    rd  = bus.prdata;
    err = bus.pslverr;
    model_read(a, exp_rd, exp_err);
    tick();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, xd;
    bit e, xe;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (timer_irq !== '0) begin
      failures++; $display("FAIL reset_irq got=%b exp=%b", timer_irq, {N{1'b0}});
    end
    apb_read(16'h0000, d, e, xd, xe);
    checks++;
    if (d !== 32'h1 || e !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got=%h/%0d exp=%h/0", d, e, 32'h1);
    end
    apb_read(16'h0004, d, e, xd, xe);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      failures++; $display("FAIL reset_status got=%h/%0d exp=0/0", d, e);
    end
    apb_read(16'h0010, d, e, xd, xe);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reset_cmp0_lo got=%h exp=ffffffff", d);
    end
    apb_read(16'h0014, d, e, xd, xe);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reset_cmp0_hi got=%h exp=ffffffff", d);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (timer_irq !== '0) begin
        failures++; $display("FAIL reset_quiet cyc=%0d got=%b exp=0", c, timer_irq);
      end
    end
  endtask

  task automatic test_ramp();
    logic [31:0] d, xd;
    bit e, xe;
    logic [63:0] sampled;
    int reached, rose;
    apb_write(16'h001C, 32'd0, e);
    apb_write(16'h0018, 32'd100, e);
    mtime   = 64'd95;
    reached = 0;
    rose    = -1;
    for (int c = 0; c < 15; c++) begin
      sampled = mtime;
      tick();
      if (sampled >= 64'd100) reached++;
      checks++;
      if (timer_irq !== m_irq) begin
        failures++; $display("FAIL ramp_model mtime=%0d got=%b exp=%b", sampled, timer_irq, m_irq);
      end
      checks++;
      if (timer_irq[0] !== 1'b0) begin
        failures++; $display("FAIL ramp_irq0 got=%b exp=0", timer_irq[0]);
      end
      if (timer_irq[1] === 1'b1 && rose < 0) rose = reached;
      mtime = mtime + 64'd1;
    end
    checks++;
    if (rose < 1 || rose > 2) begin
      failures++; $display("FAIL ramp_latency got=%0d exp=1..2", rose);
    end
    apb_read(16'h0004, d, e, xd, xe);
    checks++;
    if (d !== 32'h2) begin
      failures++; $display("FAIL ramp_status got=%h exp=2", d);
    end
  endtask

  task automatic test_rewrite();
    bit e;
    logic [63:0] sampled;
    bit all_below;
    for (int k = 0; k < N; k++) begin
      apb_write(16'h0018, 32'd100, e);
      repeat (N + 1) tick();
      checks++;
      if (timer_irq[1] !== 1'b1) begin
        failures++; $display("FAIL rewrite_pre k=%0d got=%b exp=1", k, timer_irq[1]);
      end
      for (int w = 0; w < N && ((m_phase + 1) % N) != k; w++) tick();
      apb_write(16'h0018, 32'd500, e);
      checks++;
      if (timer_irq[1] !== 1'b0 || timer_irq !== m_irq) begin
        failures++; $display("FAIL rewrite_clear scan_slot=%0d got=%b exp=%b", k, timer_irq, m_irq);
      end
      repeat (4) begin
        tick();
        checks++;
        if (timer_irq[1] !== 1'b0) begin
          failures++; $display("FAIL rewrite_hold got=%b exp=0", timer_irq[1]);
        end
      end
    end
    mtime     = 64'd495;
    all_below = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sampled = mtime;
      tick();
      if (sampled >= 64'd500) all_below = 1'b0;
      checks++;
      if (timer_irq !== m_irq || (all_below && timer_irq[1] !== 1'b0)) begin
        failures++; $display("FAIL rewrite_ramp mtime=%0d got=%b exp=%b", sampled, timer_irq, m_irq);
      end
      mtime = mtime + 64'd1;
    end
  endtask

  task automatic test_carry();
    bit e;
    mtime = 64'h1_0000_0000;
    apb_write(16'h0014, 32'h0, e);
    apb_write(16'h0010, 32'hFFFF_FFFF, e);
    repeat (N) tick();
    checks++;
    if (timer_irq[0] !== 1'b1 || timer_irq !== m_irq) begin
      failures++; $display("FAIL carry_hit got=%b exp=%b", timer_irq, m_irq);
    end
    apb_write(16'h0014, 32'h1, e);
    apb_write(16'h0010, 32'h1, e);
    repeat (N) tick();
    checks++;
    if (timer_irq[0] !== 1'b0 || timer_irq !== m_irq) begin
      failures++; $display("FAIL carry_miss got=%b exp=%b", timer_irq, m_irq);
    end
  endtask

  task automatic test_scan_en();
    logic [31:0] d, xd;
    bit e, xe;
    int n;
    checks++;
    if (timer_irq[1] !== 1'b1) begin
      failures++; $display("FAIL scan_pre got=%b exp=1", timer_irq[1]);
    end
    apb_write(16'h0000, 32'h0, e);
    apb_read(16'h0000, d, e, xd, xe);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL scan_ctrl_off got=%h exp=0", d);
    end
    mtime = 64'd0;
    repeat (5) begin
      tick();
      checks++;
      if (timer_irq[1] !== 1'b1 || timer_irq !== m_irq) begin
        failures++; $display("FAIL scan_hold got=%b exp=%b", timer_irq, m_irq);
      end
    end
    apb_write(16'h0000, 32'h1, e);
    n = 0;
    while (timer_irq[1] !== 1'b0 && n < 4) begin
      tick();
      n++;
      checks++;
      if (timer_irq !== m_irq) begin
        failures++; $display("FAIL scan_resume_model got=%b exp=%b", timer_irq, m_irq);
      end
    end
    checks++;
    if (n < 1 || n > 2) begin
      failures++; $display("FAIL scan_resume_latency got=%0d exp=1..2", n);
    end
  endtask

  task automatic test_errors();
    logic [15:0] bad [4];
    logic [15:0] good [4];
    logic [31:0] d, xd;
    bit e, xe;
    bad[0] = 16'h0008; bad[1] = 16'h0011; bad[2] = 16'h0020; bad[3] = 16'h0002;
    good[0] = 16'h0010; good[1] = 16'h0014; good[2] = 16'h0018; good[3] = 16'h001C;
    checks++;
    if (bus.pready !== 1'b1) begin
      failures++; $display("FAIL pready got=%b exp=1", bus.pready);
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(bad[i], d, e, xd, xe);
      checks++;
      if (e !== 1'b1 || d !== 32'h0) begin
        failures++; $display("FAIL err_read addr=%h got=%h/%0d exp=0/1", bad[i], d, e);
      end
      apb_write(bad[i], $urandom, e);
      checks++;
      if (e !== 1'b1) begin
        failures++; $display("FAIL err_write addr=%h got=%0d exp=1", bad[i], e);
      end
    end
    apb_write(16'h0004, $urandom, e);
    checks++;
    if (e !== 1'b0) begin
      failures++; $display("FAIL status_write_err got=%0d exp=0", e);
    end
    apb_read(16'h0000, d, e, xd, xe);
    checks++;
    if (d !== 32'h1 || e !== 1'b0) begin
      failures++; $display("FAIL err_ctrl_kept got=%h exp=1", d);
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(good[i], d, e, xd, xe);
      checks++;
      if (d !== xd || e !== xe) begin
        failures++; $display("FAIL err_cmp_kept addr=%h got=%h exp=%h", good[i], d, xd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, xd;
    bit e, xe;
    apb_write(16'h0010, 32'd5, e);
    apb_write(16'h0000, 32'h0, e);
    bus.paddr   = 16'h0014;
    bus.pwdata  = 32'h0;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    checks++;
    if (timer_irq !== '0) begin
      failures++; $display("FAIL midrst_irq got=%b exp=0", timer_irq);
    end
    apb_read(16'h0010, d, e, xd, xe);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL midrst_cmp_lo got=%h exp=ffffffff", d);
    end
    apb_read(16'h0014, d, e, xd, xe);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL midrst_cmp_hi got=%h exp=ffffffff", d);
    end
    apb_read(16'h0000, d, e, xd, xe);
    checks++;
    if (d !== 32'h1) begin
      failures++; $display("FAIL midrst_ctrl got=%h exp=1", d);
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs [10];
    logic [31:0] d, xd, wd;
    logic [15:0] a;
    bit e, xe;
    int r, slot, hi;
    addrs[0] = 16'h0000; addrs[1] = 16'h0004; addrs[2] = 16'h0010; addrs[3] = 16'h0014;
    addrs[4] = 16'h0018; addrs[5] = 16'h001C; addrs[6] = 16'h0008; addrs[7] = 16'h0020;
    addrs[8] = 16'h0024; addrs[9] = 16'h0003;
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        slot = int'($urandom_range(0, N - 1));
        hi   = int'($urandom_range(0, 1));
        a    = 16'(16 + 8 * slot + 4 * hi);
        if (hi != 0) wd = mtime[63:32] + 32'($urandom_range(0, 1));
        else         wd = mtime[31:0] + 32'($urandom_range(0, 12)) - 32'd6;
        apb_write(a, wd, e);
        checks++;
        if (e !== 1'b0) begin
          failures++; $display("FAIL rnd_write_err addr=%h got=%0d exp=0", a, e);
        end
      end else if (r == 3) begin
        apb_write(16'h0000, {31'd0, ($urandom_range(0, 3) != 0)}, e);
      end else if (r == 4) begin
        a = addrs[$urandom_range(0, 9)];
        apb_read(a, d, e, xd, xe);
        checks++;
        if (d !== xd || e !== xe) begin
          failures++; $display("FAIL rnd_read addr=%h got=%h/%0d exp=%h/%0d", a, d, e, xd, xe);
        end
      end else begin
        tick();
      end
      checks++;
      if (timer_irq !== m_irq) begin
        failures++; $display("FAIL rnd_irq it=%0d mtime=%h got=%b exp=%b", it, mtime, timer_irq, m_irq);
      end
      if ($urandom_range(0, 49) == 0) mtime = 64'hFFFF_FFFF_FFFF_FFF8;
      else                            mtime = mtime + 64'($urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    mtime       = 64'd0;
    bus.paddr   = 16'h0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = 32'h0;
    test_reset();
    test_ramp();
    test_rewrite();
    test_carry();
    test_scan_en();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
